// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and word-select helper for the SHA-256 digest
// transmit path.
package sha256_pkg;

    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NWORDS   = 8;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } tx_state_e;

    // Word idx of a digest in stream order; msw_first puts bits [255:224] at idx 0.
    function automatic logic [WORD_W-1:0] sel_word(input logic [DIGEST_W-1:0] digest,
                                                   input logic [IDX_W-1:0]    idx,
                                                   input bit                  msw_first);
        logic [IDX_W-1:0] pos;
        pos = msw_first ? (3'(NWORDS - 1) - idx) : idx;
        return digest[int'(pos) * WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/sha256_digest_tx_if.sv
// Digest input strobe and 32-bit word output stream of the digest transmitter.
interface sha256_digest_tx_if;
    import sha256_pkg::*;

    logic                s_valid;
    logic [DIGEST_W-1:0] s_data;
    logic                d_valid;
    logic [WORD_W-1:0]   d_data;
    logic                d_last;
    logic [IDX_W-1:0]    d_idx;
    logic                d_ready;

    modport master (
        output s_valid, s_data, d_ready,
        input  d_valid, d_data, d_last, d_idx
    );

    modport slave (
        input  s_valid, s_data, d_ready,
        output d_valid, d_data, d_last, d_idx
    );

endinterface

// File: rtl/sha256_dig_fifo.sv
// DEPTH-entry synchronous FIFO of 256-bit digests. Besides the current head it
// exposes the head and emptiness as they will be after this cycle's push/pop.
module sha256_dig_fifo
    import sha256_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push,
    input  logic                pop,
    input  logic [DIGEST_W-1:0] wdata,
    output logic                full,
    output logic                empty,
    output logic [DIGEST_W-1:0] head,
    output logic [DIGEST_W-1:0] head_next,
    output logic                empty_next
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DIGEST_W-1:0] mem_q [DEPTH];
    logic [DIGEST_W-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push while full is only issued together with a pop, so the write may land
    // on the slot that is being released this same cycle.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = wdata;
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full       = (cnt_q == CntW'(DEPTH));
    assign empty      = (cnt_q == '0);
    assign head       = mem_q[rd_q];
    assign head_next  = mem_d[rd_d];
    assign empty_next = (cnt_d == '0);

endmodule

// File: rtl/sha256_digest_tx.sv
// Buffers 256-bit digests from the hash core and streams each one out as eight
// 32-bit words with a last marker; digests arriving with the buffer full are dropped.
module sha256_digest_tx
    import sha256_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter bit          MSW_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sha256_digest_tx_if.slave        bus,
    output logic                     busy,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    logic                full, empty, empty_next;
    logic [DIGEST_W-1:0] head, head_next;
    logic                accept, pop, push, drop;

    tx_state_e           state_q;
    logic                d_valid_q, d_last_q, busy_q, ovf_q;
    logic [WORD_W-1:0]   d_data_q;
    logic [IDX_W-1:0]    d_idx_q;

    assign accept = d_valid_q & bus.d_ready;
    assign pop    = accept & (d_idx_q == 3'(NWORDS - 1)) & ~empty;
    // A pop frees a slot in the same cycle, so a full buffer still takes the digest.
    assign push   = bus.s_valid & (~full | pop);
    assign drop   = bus.s_valid & full & ~pop;

    sha256_dig_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .wdata      (bus.s_data),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .head_next  (head_next),
        .empty_next (empty_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            d_valid_q <= 1'b0;
            d_data_q  <= '0;
            d_idx_q   <= '0;
            d_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            busy_q <= ~empty_next;

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!empty_next) begin
                        state_q   <= SEND;
                        d_valid_q <= 1'b1;
                        d_idx_q   <= '0;
                        d_data_q  <= sel_word(head_next, '0, MSW_FIRST);
                        d_last_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (!pop) begin
                            d_idx_q  <= d_idx_q + 3'd1;
                            d_data_q <= sel_word(head, d_idx_q + 3'd1, MSW_FIRST);
                            d_last_q <= (d_idx_q == 3'(NWORDS - 2));
                        end else if (!empty_next) begin
                            // Next digest follows with no idle cycle.
                            d_idx_q  <= '0;
                            d_data_q <= sel_word(head_next, '0, MSW_FIRST);
                            d_last_q <= 1'b0;
                        end else begin
                            state_q   <= IDLE;
                            d_valid_q <= 1'b0;
                            d_idx_q   <= '0;
                            d_data_q  <= '0;
                            d_last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    d_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d_valid = d_valid_q;
    assign bus.d_data  = d_data_q;
    assign bus.d_idx   = d_idx_q;
    assign bus.d_last  = d_last_q;
    assign busy        = busy_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Directed bench for sha256_digest_tx: an MSW-first and an LSW-first instance share
// stimulus; expected words are queued on push and checked as the stream delivers them.
module tb_sha256_digest_tx;
    import sha256_pkg::*;

    localparam logic [255:0] DIG_A =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_B =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_C =
        256'h00112233445566778899aabbccddeeff0123456789abcdeffedcba9876543210;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s_valid, d_ready, ovf_clr;
    logic [255:0] s_data;
    logic         busy_m, ovf_m, busy_l, ovf_l;

    exp_t q_m[$];
    exp_t q_l[$];
    int   total = 0;
    int   bad   = 0;
    int   acc [2];
    logic stall [2];

    always #5 clk = ~clk;

    sha256_digest_tx_if bus_m ();
    sha256_digest_tx_if bus_l ();

    assign bus_m.s_valid = s_valid;
    assign bus_m.s_data  = s_data;
    assign bus_m.d_ready = d_ready;
    assign bus_l.s_valid = s_valid;
    assign bus_l.s_data  = s_data;
    assign bus_l.d_ready = d_ready;

    sha256_digest_tx #(.DEPTH(2), .MSW_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .bus(bus_m), .busy(busy_m), .ovf(ovf_m),
        .ovf_clr(ovf_clr)
    );

    sha256_digest_tx #(.DEPTH(2), .MSW_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .bus(bus_l), .busy(busy_l), .ovf(ovf_l),
        .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input logic [255:0] d);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.idx  = 3'(i);
            e.last = (i == 7);
            e.w    = d[255 - 32*i -: 32];
            q_m.push_back(e);
            e.w    = d[32*i +: 32];
            q_l.push_back(e);
        end
    endfunction

    // Every valid word must equal the queue head; an accept retires it.
    task automatic mon(input int k, input logic v, input logic r, input logic [31:0] d,
                       input logic [2:0] i, input logic l);
        exp_t  e;
        string p;
        p = (k == 0) ? "msw" : "lsw";
        if (reset_n !== 1'b1) begin
            stall[k] = 1'b0;
            return;
        end
        if (stall[k]) chk1({p, "_valid_held"}, v, 1'b1);
        if (v === 1'b1) begin
            if (((k == 0) ? q_m.size() : q_l.size()) == 0) begin
                chk1({p, "_spurious_valid"}, v, 1'b0);
            end else begin
                e = (k == 0) ? q_m[0] : q_l[0];
                chk({p, "_data"}, d, e.w);
                chk({p, "_idx"}, 32'(i), 32'(e.idx));
                chk1({p, "_last"}, l, e.last);
                if (r === 1'b1) begin
                    if (k == 0) void'(q_m.pop_front());
                    else        void'(q_l.pop_front());
                    acc[k]++;
                end
            end
        end else begin
            chk1({p, "_last_idle"}, l, 1'b0);
        end
        stall[k] = (v === 1'b1) && (r !== 1'b1);
    endtask

    always @(negedge clk) mon(0, bus_m.d_valid, bus_m.d_ready, bus_m.d_data, bus_m.d_idx,
                              bus_m.d_last);
    always @(negedge clk) mon(1, bus_l.d_valid, bus_l.d_ready, bus_l.d_data, bus_l.d_idx,
                              bus_l.d_last);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((q_m.size() != 0 || q_l.size() != 0) && n < max) begin
            step();
            n++;
        end
        chk("drain_msw", q_m.size(), 0);
        chk("drain_lsw", q_l.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_valid"}, bus_m.d_valid, 1'b0);
        chk({tag, "_data"}, bus_m.d_data, 32'h0);
        chk({tag, "_idx"}, 32'(bus_m.d_idx), 32'h0);
        chk1({tag, "_last"}, bus_m.d_last, 1'b0);
        chk1({tag, "_busy"}, busy_m, 1'b0);
        chk1({tag, "_ovf"}, ovf_m, 1'b0);
        chk1({tag, "_valid_lsw"}, bus_l.d_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int  a0;
        int  n;
        bit  injected;

        acc[0] = 0; acc[1] = 0; stall[0] = 1'b0; stall[1] = 1'b0;
        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; d_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();

        // Single digest, ready high: word 0 one cycle after the strobe, then 8 in a row.
        d_ready = 1'b1;
        s_data  = DIG_A; s_valid = 1'b1; push_exp(DIG_A);
        step();
        s_valid = 1'b0; s_data = DIG_C;
        chk1("latency_valid", bus_m.d_valid, 1'b1);
        chk("latency_word0_msw", bus_m.d_data, 32'hba7816bf);
        chk("latency_word0_lsw", bus_l.d_data, 32'hf20015ad);
        a0 = acc[0];
        repeat (8) step();
        chk("single_accepts", 32'(acc[0] - a0), 32'd8);
        chk1("single_busy_after", busy_m, 1'b0);
        chk1("single_valid_after", bus_m.d_valid, 1'b0);
        chk("single_drained", q_m.size(), 0);

        // Back-pressure with ready pattern 1,0,0,1,0,0,...
        a0 = acc[0];
        s_data = DIG_A; s_valid = 1'b1; push_exp(DIG_A);
        step();
        s_valid = 1'b0;
        n = 0;
        while (q_m.size() != 0 && n < 60) begin
            d_ready = (n % 3 == 0);
            step();
            n++;
        end
        d_ready = 1'b1;
        wait_drain(20);
        step();
        chk("bp_accepts", 32'(acc[0] - a0), 32'd8);
        chk1("bp_busy_after", busy_m, 1'b0);

        // Overflow: A and B fill the buffer, C is dropped; set wins over clear.
        d_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = DIG_A; push_exp(DIG_A); step();
        s_data  = DIG_B; push_exp(DIG_B); step();
        chk1("ovf_before_c", ovf_m, 1'b0);
        s_data  = DIG_C; step();
        s_valid = 1'b0;
        chk1("ovf_set", ovf_m, 1'b1);
        chk1("ovf_set_lsw", ovf_l, 1'b1);
        repeat (5) step();
        chk1("ovf_sticky", ovf_m, 1'b1);
        chk1("ovf_busy", busy_m, 1'b1);
        s_valid = 1'b1; s_data = DIG_C; ovf_clr = 1'b1;
        step();
        s_valid = 1'b0;
        chk1("ovf_set_beats_clr", ovf_m, 1'b1);
        step();
        ovf_clr = 1'b0;
        chk1("ovf_cleared", ovf_m, 1'b0);
        a0 = acc[0];
        d_ready = 1'b1;
        wait_drain(40);
        repeat (4) step();
        chk("ovf_accepts_ab_only", 32'(acc[0] - a0), 32'd16);
        chk1("ovf_busy_after", busy_m, 1'b0);

        // Full buffer, C pulsed as A's word 7 is accepted: taken, no ovf, no bubbles.
        d_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = DIG_A; push_exp(DIG_A); step();
        s_data  = DIG_B; push_exp(DIG_B); step();
        s_valid = 1'b0;
        step();
        d_ready  = 1'b1;
        a0       = acc[0];
        injected = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!injected && bus_m.d_valid === 1'b1 && bus_m.d_idx === 3'd7) begin
                s_valid = 1'b1; s_data = DIG_C; push_exp(DIG_C); injected = 1'b1;
            end
            step();
            s_valid = 1'b0;
        end
        chk1("coll_injected", injected, 1'b1);
        chk1("coll_ovf", ovf_m, 1'b0);
        chk("coll_accepts_no_bubble", 32'(acc[0] - a0), 32'd24);
        chk1("coll_busy_after", busy_m, 1'b0);
        wait_drain(4);

        // Reset with word 3 on the outputs, then a fresh digest starts at word 0.
        s_data = DIG_B; s_valid = 1'b1; push_exp(DIG_B);
        step();
        s_valid = 1'b0;
        n = 0;
        while (bus_m.d_idx !== 3'd3 && n < 20) begin
            step();
            n++;
        end
        chk("mid_reached_idx3", 32'(bus_m.d_idx), 32'd3);
        reset_n = 1'b0;
        q_m.delete();
        q_l.delete();
        step();
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        step();
        chk1("post_reset_empty_valid", bus_m.d_valid, 1'b0);
        chk1("post_reset_empty_busy", busy_m, 1'b0);
        s_data = DIG_C; s_valid = 1'b1; push_exp(DIG_C);
        step();
        s_valid = 1'b0;
        chk("post_reset_idx0", 32'(bus_m.d_idx), 32'd0);
        chk("post_reset_word0", bus_m.d_data, 32'h00112233);
        wait_drain(20);
        step();
        chk1("final_busy", busy_m, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_digest_tx.md
# sha256_digest_tx

Transmit side of the SHA-256 core's result interface. The block captures each 256-bit digest pulsed out by the hash core on `s_valid`/`s_data`. It buffers up to DEPTH digests and serialises each one as eight 32-bit words on a valid/ready stream with a last marker. It sits between the hash core and the word-wide consumer (register bank, DMA or UART bridge). Digests that arrive when the buffer is full are dropped and flagged.

## Interface
- `DEPTH`, 2: digest buffer entries; legal values 1 or 2.
- `MSW_FIRST`, 1: 1 sends word 0 = `s_data[255:224]` first; 0 sends `s_data[31:0]` first.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `s_valid`  in  1  one-cycle digest strobe from the hash core; there is no back-pressure.
- `s_data`  in  256  digest; valid only when `s_valid`=1.
- `d_valid`  out  1  output word valid.
- `d_data`  out  32  output word.
- `d_last`  out  1  high with the 8th word of a digest.
- `d_idx`  out  3  index of the current word, 0..7.
- `d_ready`  in  1  consumer accepts the word when `d_valid`&`d_ready`.
- `busy`  out  1  buffer non-empty or a digest is being sent.
- `ovf`  out  1  sticky flag: a digest was dropped.
- `ovf_clr`  in  1  clears `ovf`.

## Operation
- Buffer: FIFO of DEPTH×256 bits.
  - Push on `s_valid` when the buffer is not full.
  - Pop when the last word of the head digest is accepted.
- Full push/pop collision: if the buffer is full and a pop happens in the same cycle as `s_valid`, the push is accepted and `ovf` is not set.
- Overflow: `s_valid` with the buffer full and no pop drops the digest and sets `ovf`.
- `ovf` clear: `ovf_clr` clears `ovf`. If a set and a clear happen in the same cycle, the set wins.
- FSM:
  - IDLE: `d_valid`=0. Go to SEND when the buffer is non-empty.
  - SEND: present word `d_idx` of the head digest.
    - On accept with `d_idx`<7, increment `d_idx`.
    - On accept with `d_idx`=7, wrap `d_idx` to 0 and pop the head.
    - After that pop, stay in SEND if another digest remains, otherwise go to IDLE.
- Word selection: `d_data` = head digest word `d_idx`, in the order set by MSW_FIRST. `d_last` = (`d_idx`==7) & `d_valid`.
- Stream stability: while `d_valid`=1 and `d_ready`=0, `d_data`, `d_idx` and `d_last` hold stable. `d_valid` never deasserts without an accept.
- `busy` = (state==SEND) | buffer non-empty.

## Timing
- Reset values:
  - `d_valid`=0, `d_data`=0, `d_last`=0, `d_idx`=0, `busy`=0, `ovf`=0.
  - Buffer empty, FSM in IDLE.
- Reset mid-transfer: the in-flight digest and all buffered digests are discarded. Outputs return to reset values on the next edge.
- Latency: `s_valid` at cycle N (buffer empty) gives `d_valid`=1 with word 0 at cycle N+1.
- Throughput: with `d_ready` held high, one word per cycle. Back-to-back digests have no bubble: word 7 accepted at cycle M puts the next digest's word 0 on the outputs at M+1.
- Fill timing: a digest pushed in the same cycle the buffer goes empty is sent starting the next cycle.
- All outputs are registered.

## Structure
- Shared package `sha256_pkg`: `DIGEST_W`=256, `WORD_W`=32, `NWORDS`=8, and the FSM state enum `{IDLE, SEND}`.
- One sub-module, `sha256_dig_fifo`:
  - Parameterised DEPTH-entry, 256-bit synchronous FIFO.
  - Signals: push, pop, full, empty, head.
  - Pointer wrap-around is handled inside it.
- Top level holds the FSM, word counter, mux and `ovf` logic.

## Test plan
- Single digest, SHA-256("abc"): pulse `s_valid` with `s_data`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, `d_ready`=1.
  - Required: words ba7816bf … f20015ad on 8 consecutive cycles starting N+1.
  - `d_last` high only on f20015ad; `busy` low after the last word.
- Back-pressure: same digest, `d_ready` toggled 1,0,0,1,….
  - Required: `d_data` and `d_idx` hold during stalls; exactly 8 accepts in order.
- MSW_FIRST=0: same digest.
  - Required: first word f20015ad, last word ba7816bf.
- Overflow, DEPTH=2, `d_ready`=0: three `s_valid` pulses with digests A, B, C.
  - Required: `ovf`=1 after C, and `ovf` stays 1 until `ovf_clr`.
  - Required: releasing `d_ready` yields A then B (16 words) and no C.
- Full push/pop collision: with the buffer full, pulse `s_valid` with digest C in the same cycle word 7 of A is accepted.
  - Required: C is accepted, `ovf` stays 0, and the output sequence is A, B, C.
- Reset mid-transfer: assert `reset_n`=0 while `d_idx`=3.
  - Required: next cycle all outputs 0 and the buffer empty. A new digest then starts again at word 0.
